// File: rtl/ddr3_cmd_pkg.sv
// Shared opcodes, DRAM pin encodings and address bit positions for the DDR3 command stage.
package ddr3_cmd_pkg;

    typedef enum logic [3:0] {
        CMD_NOP  = 4'd0,
        CMD_ACT  = 4'd1,
        CMD_RD   = 4'd2,
        CMD_WR   = 4'd3,
        CMD_PRE  = 4'd4,
        CMD_PREA = 4'd5,
        CMD_REF  = 4'd6,
        CMD_MRS  = 4'd7,
        CMD_ZQCL = 4'd8
    } cmd_e;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] PIN_RST  = 4'b1111;
    localparam logic [3:0] PIN_NOP  = 4'b0111;
    localparam logic [3:0] PIN_ACT  = 4'b0011;
    localparam logic [3:0] PIN_RD   = 4'b0101;
    localparam logic [3:0] PIN_WR   = 4'b0100;
    localparam logic [3:0] PIN_PRE  = 4'b0010;
    localparam logic [3:0] PIN_REF  = 4'b0001;
    localparam logic [3:0] PIN_MRS  = 4'b0000;
    localparam logic [3:0] PIN_ZQCL = 4'b0110;

    localparam int unsigned A10_BIT = 10;

endpackage

// File: rtl/ddr3_bank_timer.sv
// Per-bank timing counters (tRCD, tRAS, tRP, tWTP) and the open-row flag.
module ddr3_bank_timer #(
    parameter int unsigned CNT_W = 10,
    parameter int unsigned T_RCD = 11,
    parameter int unsigned T_RAS = 28,
    parameter int unsigned T_RP  = 11,
    parameter int unsigned T_WTP = 24
) (
    input  logic clk1,
    input  logic rst,
    input  logic act_i,
    input  logic wr_i,
    input  logic pre_i,
    output logic open_o,
    output logic rcd_zero_o,
    output logic ras_zero_o,
    output logic rp_zero_o,
    output logic wtp_zero_o
);

    logic [CNT_W-1:0] rcd_q, rcd_d, ras_q, ras_d, rp_q, rp_d, wtp_q, wtp_d;
    logic             open_q, open_d;

    function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] c);
        return (c == '0) ? c : c - CNT_W'(1);
    endfunction

    // Load on the owning command, otherwise count down and hold at zero.
    always_comb begin
        rcd_d  = act_i ? CNT_W'(T_RCD - 1) : dec_sat(rcd_q);
        ras_d  = act_i ? CNT_W'(T_RAS - 1) : dec_sat(ras_q);
        rp_d   = pre_i ? CNT_W'(T_RP - 1)  : dec_sat(rp_q);
        wtp_d  = wr_i  ? CNT_W'(T_WTP - 1) : dec_sat(wtp_q);
        open_d = open_q;
        if (act_i) begin
            open_d = 1'b1;
        end else if (pre_i) begin
            open_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk1) begin
        if (rst) begin
            rcd_q  <= '0;
            ras_q  <= '0;
            rp_q   <= '0;
            wtp_q  <= '0;
            open_q <= 1'b0;
        end else begin
            rcd_q  <= rcd_d;
            ras_q  <= ras_d;
            rp_q   <= rp_d;
            wtp_q  <= wtp_d;
            open_q <= open_d;
        end
    end

    assign open_o     = open_q;
    assign rcd_zero_o = (rcd_q == '0);
    assign ras_zero_o = (ras_q == '0);
    assign rp_zero_o  = (rp_q == '0);
    assign wtp_zero_o = (wtp_q == '0);

endmodule

// File: rtl/ddr3_cmd_issue_phy.sv
// DDR3 command-pin stage: legality and timing gating, bank tracking, pin encoding.
module ddr3_cmd_issue_phy
    import ddr3_cmd_pkg::*;
#(
    parameter int unsigned NUM_BANKS = 8,
    parameter int unsigned BA_BITS   = 3,
    parameter int unsigned ADDR_BITS = 16,
    parameter int unsigned CNT_W     = 10,
    parameter int unsigned T_RCD     = 11,
    parameter int unsigned T_RP      = 11,
    parameter int unsigned T_RAS     = 28,
    parameter int unsigned T_RRD     = 5,
    parameter int unsigned T_WTP     = 24,
    parameter int unsigned T_MRD     = 4,
    parameter int unsigned T_RFC     = 128,
    parameter int unsigned T_ZQ      = 512
) (
    input  logic                 clk1,
    input  logic                 rst,
    input  logic                 i_cke_en,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic [3:0]           i_cmd,
    input  logic [BA_BITS-1:0]   i_cmd_ba,
    input  logic [ADDR_BITS-1:0] i_cmd_addr,
    output logic                 o_cmd_err,
    output logic [NUM_BANKS-1:0] o_bank_open,
    output logic                 cke,
    output logic                 cs_n,
    output logic                 ras_n,
    output logic                 cas_n,
    output logic                 we_n,
    output logic [BA_BITS-1:0]   ba,
    output logic [ADDR_BITS-1:0] addr
);

    logic [NUM_BANKS-1:0] sel, act_ld, wr_ld, pre_ld;
    logic [NUM_BANKS-1:0] rcd_z, ras_z, rp_z, wtp_z;
    logic                 illegal, gate, accept, issue;
    cmd_e                 cmd;

    logic [CNT_W-1:0]     rrd_q, rrd_d, blk_q, blk_d;
    logic [3:0]           pins_q, pins_d;
    logic [BA_BITS-1:0]   ba_q, ba_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic                 err_q, err_d, cke_q;

    // Bank select, legality against current open flags, and timing gate.
    always_comb begin
        cmd = cmd_e'(i_cmd);
        sel = '0;
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            sel[i] = (i_cmd_ba == BA_BITS'(i));
        end
        illegal = 1'b0;
        gate    = 1'b1;
        case (cmd)
            CMD_ACT: begin
                illegal = ~(|sel) | (|(sel & o_bank_open));
                gate    = (|(sel & rp_z)) & (rrd_q == '0) & (blk_q == '0);
            end
            CMD_RD, CMD_WR: begin
                illegal = ~(|(sel & o_bank_open));
                gate    = (|(sel & rcd_z)) & (blk_q == '0);
            end
            CMD_PRE: begin
                illegal = ~(|sel);
                gate    = (|(sel & ras_z & wtp_z)) & (blk_q == '0);
            end
            CMD_PREA: gate = (&(~o_bank_open | (ras_z & wtp_z))) & (blk_q == '0);
            CMD_REF: begin
                illegal = |o_bank_open;
                gate    = (&rp_z) & (blk_q == '0);
            end
            CMD_MRS, CMD_ZQCL: begin
                illegal = |o_bank_open;
                gate    = (blk_q == '0);
            end
            default: gate = 1'b1;
        endcase
        o_cmd_ready = ~rst & (illegal | gate);
        accept      = i_cmd_valid & o_cmd_ready;
        issue       = accept & ~illegal & (cmd != CMD_NOP) & (i_cmd <= 4'(CMD_ZQCL));
        act_ld      = (issue && cmd == CMD_ACT) ? sel : '0;
        wr_ld       = (issue && cmd == CMD_WR) ? sel : '0;
        pre_ld      = (issue && cmd == CMD_PRE)  ? sel :
                      (issue && cmd == CMD_PREA) ? '1 : '0;
    end

    // Pin encoding, global counters and error pulse for the next edge.
    always_comb begin
        pins_d = PIN_NOP;
        ba_d   = ba_q;
        addr_d = addr_q;
        err_d  = accept & illegal;
        rrd_d  = (rrd_q == '0) ? rrd_q : rrd_q - CNT_W'(1);
        blk_d  = (blk_q == '0) ? blk_q : blk_q - CNT_W'(1);
        if (issue) begin
            case (cmd)
                CMD_ACT: begin
                    pins_d = PIN_ACT;
                    ba_d   = i_cmd_ba;
                    addr_d = i_cmd_addr;
                    rrd_d  = CNT_W'(T_RRD - 1);
                end
                CMD_RD, CMD_WR: begin
                    pins_d          = (cmd == CMD_RD) ? PIN_RD : PIN_WR;
                    ba_d            = i_cmd_ba;
                    addr_d          = i_cmd_addr;
                    addr_d[A10_BIT] = 1'b0;
                end
                CMD_PRE: begin
                    pins_d          = PIN_PRE;
                    ba_d            = i_cmd_ba;
                    addr_d          = i_cmd_addr;
                    addr_d[A10_BIT] = 1'b0;
                end
                CMD_PREA: begin
                    pins_d          = PIN_PRE;
                    addr_d          = i_cmd_addr;
                    addr_d[A10_BIT] = 1'b1;
                end
                CMD_REF: begin
                    pins_d = PIN_REF;
                    blk_d  = CNT_W'(T_RFC - 1);
                end
                CMD_MRS: begin
                    pins_d = PIN_MRS;
                    ba_d   = i_cmd_ba;
                    addr_d = i_cmd_addr;
                    blk_d  = CNT_W'(T_MRD - 1);
                end
                CMD_ZQCL: begin
                    pins_d          = PIN_ZQCL;
                    ba_d            = '0;
                    addr_d          = '0;
                    addr_d[A10_BIT] = 1'b1;
                    blk_d           = CNT_W'(T_ZQ - 1);
                end
                default: pins_d = PIN_NOP;
            endcase
        end
    end

    // Output and global-counter registers with synchronous reset.
    always_ff @(posedge clk1) begin
        if (rst) begin
            pins_q <= PIN_RST;
            ba_q   <= '0;
            addr_q <= '0;
            err_q  <= 1'b0;
            cke_q  <= 1'b0;
            rrd_q  <= '0;
            blk_q  <= '0;
        end else begin
            pins_q <= pins_d;
            ba_q   <= ba_d;
            addr_q <= addr_d;
            err_q  <= err_d;
            cke_q  <= i_cke_en;
            rrd_q  <= rrd_d;
            blk_q  <= blk_d;
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        ddr3_bank_timer #(
            .CNT_W(CNT_W), .T_RCD(T_RCD), .T_RAS(T_RAS), .T_RP(T_RP), .T_WTP(T_WTP)
        ) u_timer (
            .clk1      (clk1),
            .rst       (rst),
            .act_i     (act_ld[g]),
            .wr_i      (wr_ld[g]),
            .pre_i     (pre_ld[g]),
            .open_o    (o_bank_open[g]),
            .rcd_zero_o(rcd_z[g]),
            .ras_zero_o(ras_z[g]),
            .rp_zero_o (rp_z[g]),
            .wtp_zero_o(wtp_z[g])
        );
    end

    assign {cs_n, ras_n, cas_n, we_n} = pins_q;
    assign ba        = ba_q;
    assign addr      = addr_q;
    assign o_cmd_err = err_q;
    assign cke       = cke_q;

endmodule

// File: doc/ddr3_cmd_issue_phy.md
Name: ddr3_cmd_issue_phy

Overview:
- Parametrised DDR3 command-pin stage with bank-state tracking and timing checks.
- Sits between the command scheduler and the DRAM pins.
- Accepts one abstract command per cycle on a valid/ready handshake and enforces per-bank and global timing before issuing.
- Encodes each issued command onto cke/cs_n/ras_n/cas_n/we_n/ba/addr one cycle after acceptance, covering ACT/RD/WR/PRE/PREA/REF/MRS/ZQCL.

Parameters:
- NUM_BANKS, 8, number of banks tracked.
- BA_BITS, 3, bank address width (2^BA_BITS >= NUM_BANKS).
- ADDR_BITS, 16, address bus width.
- CNT_W, 10, timing counter width; must hold the largest T_* value.
- T_RCD, 11, ACT to RD/WR on the same bank.
- T_RP, 11, PRE/PREA to ACT or REF.
- T_RAS, 28, ACT to PRE on the same bank.
- T_RRD, 5, ACT to ACT on any bank.
- T_WTP, 24, WR to PRE on the same bank.
- T_MRD, 4, MRS to any command.
- T_RFC, 128, REF to any command.
- T_ZQ, 512, ZQCL to any command.

Ports:
- clk1  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- i_cke_en  in  1  request to raise cke.
- i_cmd_valid  in  1  command valid.
- o_cmd_ready  out  1  command may be accepted this cycle.
- i_cmd  in  4  cmd_e opcode.
- i_cmd_ba  in  BA_BITS  target bank; MR index for MRS.
- i_cmd_addr  in  ADDR_BITS  row (ACT), column (RD/WR) or MR payload (MRS).
- o_cmd_err  out  1  one-cycle pulse: an illegal command was accepted and dropped.
- o_bank_open  out  NUM_BANKS  per-bank open-row flag.
- cke, cs_n, ras_n, cas_n, we_n  out  1 each  DRAM command pins.
- ba  out  BA_BITS  DRAM bank address.
- addr  out  ADDR_BITS  DRAM address.

Behaviour:
- Reset: one clock, synchronous, active-high. While rst is high:
  - cke=0; cs_n, ras_n, cas_n, we_n = 1; ba=0; addr=0.
  - o_cmd_err=0, o_bank_open=0, o_cmd_ready=0.
  - All counters clear to 0.
  - Reset mid-operation abandons all timing state; no command is issued in the reset cycle.
- cke: registered copy of i_cke_en.
- Acceptance and latency:
  - A command is accepted on (i_cmd_valid & o_cmd_ready).
  - Pins take the command's encoding on the next edge (latency 1).
  - Cycles with no acceptance drive NOP: {cs_n,ras_n,cas_n,we_n}=0111, with ba/addr holding their previous values.
- Pin encodings {cs_n,ras_n,cas_n,we_n}: ACT 0011, RD 0101, WR 0100, PRE/PREA 0010, REF 0001, MRS 0000, ZQCL 0110.
- Address and bank mapping:
  - ACT: ba=i_cmd_ba, addr=row.
  - RD/WR: ba=i_cmd_ba, addr=column with A10 forced to 0.
  - PRE: A10=0. PREA: A10=1, ba held.
  - ZQCL: addr=1024 (A10=1), ba=0.
  - MRS: ba=MR index, addr=payload.
  - REF: ba/addr held.
- Legality, checked against the current o_bank_open. An illegal command is ready immediately (not timing-gated), is accepted, is dropped (pins NOP), and pulses o_cmd_err the next cycle. Illegal cases:
  - ACT to an open bank.
  - RD/WR to an idle bank.
  - REF, MRS or ZQCL while any bank is open.
- PRE to an idle bank is legal: it is issued and reloads that bank's tRP counter.
- Timing model:
  - Each counter loads T-1 when its command is accepted, decrements to 0 and saturates there.
  - A gated command is ready only when all relevant counters are 0. So the earliest successor acceptance = predecessor acceptance cycle + T.
  - If a load and a decrement coincide on the same counter, the load wins.
- Per-bank counters: rcd, ras, rp, wtp.
- Global counters: rrd, and blk (loaded by MRS/REF/ZQCL with T_MRD/T_RFC/T_ZQ; gates every command).
- Ready gating:
  - ACT: rp[b], rrd and blk are 0.
  - RD: rcd[b] and blk are 0.
  - WR: rcd[b] and blk are 0; WR additionally loads wtp[b].
  - PRE: ras[b], wtp[b] and blk are 0.
  - PREA: ras and wtp are 0 on every open bank; blk is 0.
  - REF: rp is 0 on all banks; blk is 0.
  - MRS/ZQCL: blk is 0.
  - NOP (i_cmd=NOP): always ready, issues nothing.
- Bank state:
  - o_bank_open[b] sets on ACT acceptance.
  - It clears on PRE to b or on PREA (all banks).
  - It updates the edge after acceptance, coincident with the pins.
- PREA loads rp on all banks.
- o_cmd_ready is combinational from i_cmd, i_cmd_ba and registered state. It has no dependency on i_cmd_valid.

Decomposition:
- Shared package ddr3_cmd_pkg holds:
  - cmd_e enum: NOP, ACT, RD, WR, PRE, PREA, REF, MRS, ZQCL.
  - The 4-bit pin encodings for each command.
  - The A10 bit index.
- One sub-module, ddr3_bank_timer: per-bank rcd/ras/rp/wtp counters plus the open flag. Instantiated NUM_BANKS times via generate.

Test Plan:
- Reset with rst=1 for 3 cycles while driving ACT valid: pins stay 1111, cke=0, ready=0 and o_bank_open=0 throughout. The cycle after release shows NOP.
- ACT bank 2, row 0x1A5 at cycle 10; RD bank 2 held valid: ready low through cycle 20, accepted at 21. Pins show 0011/ba=2/addr=0x1A5 at cycle 11 and 0101 at cycle 22.
- ACT bank 0 at cycle 0 then ACT bank 1 valid: accepted at cycle 5 (T_RRD). PRE bank 0 is not accepted before cycle 28 (T_RAS).
- WR bank 3 accepted 30 cycles after its ACT, then PRE bank 3: accepted exactly 24 cycles after the WR. The pins then show A10=0, and o_bank_open[3] clears on the same edge.
- Any bank open, then MRS: accepted at once, pins NOP, o_cmd_err pulses one cycle. After PREA plus 11 cycles, MRS ba=1, addr=0x0044 issues 0000, and the next command waits 4 cycles.
- ZQCL with all banks idle: pins 0110 with addr=1024. A following REF is ready exactly 512 cycles later; raising rst at cycle 100 clears blk and the open flags.
